// File: rtl/line_rasterizer.sv
// Bresenham line rasteriser: one framebuffer address/colour beat per pixel.
// Define LINE_PATTERN_EN to add the 16-bit dash pattern input (pattern_in).
module line_rasterizer #(
    parameter int COORD_WIDTH    = 10,
    parameter int ADDRESS_WIDTH  = 18,
    parameter int LINE_STRIDE    = 640,
    parameter int DISPLAY_HEIGHT = 400,
    parameter int COLOR_WIDTH    = 4
) (
    input  logic                     clock_in,
    input  logic                     reset_n_in,
    input  logic                     enable_in,
    input  logic [COORD_WIDTH-1:0]   x0_in,
    input  logic [COORD_WIDTH-1:0]   y0_in,
    input  logic [COORD_WIDTH-1:0]   x1_in,
    input  logic [COORD_WIDTH-1:0]   y1_in,
    input  logic [COLOR_WIDTH-1:0]   color_in,
`ifdef LINE_PATTERN_EN
    input  logic [15:0]              pattern_in,
`endif
    output logic                     ready_out,
    output logic                     pixel_valid_out,
    input  logic                     pixel_ready_in,
    output logic [ADDRESS_WIDTH-1:0] address_out,
    output logic [COLOR_WIDTH-1:0]   color_out
);

    localparam int W = COORD_WIDTH + 2;
    localparam logic [31:0] X_LIMIT = 32'(LINE_STRIDE);
    localparam logic [31:0] Y_LIMIT = 32'(DISPLAY_HEIGHT);
    localparam logic signed [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW
    } state_t;

    state_t state_q, state_d;

    logic [COORD_WIDTH-1:0] x0_q, y0_q, x1_q, y1_q;
    logic [COLOR_WIDTH-1:0] color_q;

    logic signed [W-1:0] dx_q, dy_q, err_q;
    logic signed [W-1:0] x_q, y_q;
    logic                sx_neg_q, sy_neg_q;

`ifdef LINE_PATTERN_EN
    logic [15:0] pattern_q;
    logic [3:0]  idx_q;
`endif

    logic accept, advance, drawable, in_bounds, at_end;

    logic signed [W-1:0] x0_s, y0_s, x1_s, y1_s;
    logic signed [W-1:0] dx_s, ady_s;
    logic signed [W-1:0] e2, err_n, x_n, y_n;
    logic                step_x, step_y;
    logic [31:0]         x_ext, y_ext;

    assign x0_s = $signed({2'b00, x0_q});
    assign y0_s = $signed({2'b00, y0_q});
    assign x1_s = $signed({2'b00, x1_q});
    assign y1_s = $signed({2'b00, y1_q});

    assign dx_s  = (x1_s >= x0_s) ? (x1_s - x0_s) : (x0_s - x1_s);
    assign ady_s = (y1_s >= y0_s) ? (y1_s - y0_s) : (y0_s - y1_s);

    // One Bresenham step from the current point
    assign e2     = err_q <<< 1;
    assign step_x = (e2 >= dy_q);
    assign step_y = (e2 <= dx_q);

    always_comb begin
        err_n = err_q;
        x_n   = x_q;
        y_n   = y_q;
        if (step_x) begin
            err_n = err_n + dy_q;
            x_n   = sx_neg_q ? (x_q - ONE) : (x_q + ONE);
        end
        if (step_y) begin
            err_n = err_n + dx_q;
            y_n   = sy_neg_q ? (y_q - ONE) : (y_q + ONE);
        end
    end

    // Coordinates never go negative: they stay between the two endpoints
    assign x_ext     = 32'($unsigned(x_q));
    assign y_ext     = 32'($unsigned(y_q));
    assign in_bounds = (x_ext < X_LIMIT) && (y_ext < Y_LIMIT);
    assign at_end    = (x_q == x1_s) && (y_q == y1_s);

`ifdef LINE_PATTERN_EN
    assign drawable = in_bounds && pattern_q[idx_q];
`else
    assign drawable = in_bounds;
`endif

    assign address_out = ADDRESS_WIDTH'(y_ext * X_LIMIT + x_ext);
    assign color_out   = color_q;

    always_comb begin
        state_d         = state_q;
        ready_out       = 1'b0;
        pixel_valid_out = 1'b0;
        accept          = 1'b0;
        advance         = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_out = 1'b1;
                if (enable_in) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = DRAW;
            end
            DRAW: begin
                pixel_valid_out = drawable;
                advance = drawable ? pixel_ready_in : 1'b1;
                if (advance && at_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            color_q  <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else if (accept) begin
            x0_q    <= x0_in;
            y0_q    <= y0_in;
            x1_q    <= x1_in;
            y1_q    <= y1_in;
            color_q <= color_in;
        end else if (state_q == SETUP) begin
            dx_q     <= dx_s;
            dy_q     <= -ady_s;
            err_q    <= dx_s - ady_s;
            sx_neg_q <= (x1_s < x0_s);
            sy_neg_q <= (y1_s < y0_s);
            x_q      <= x0_s;
            y_q      <= y0_s;
        end else if (advance && !at_end) begin
            err_q <= err_n;
            x_q   <= x_n;
            y_q   <= y_n;
        end
    end

`ifdef LINE_PATTERN_EN
    // Index counts every point, clipped ones included
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            pattern_q <= '0;
            idx_q     <= '0;
        end else if (accept) begin
            pattern_q <= pattern_in;
        end else if (state_q == SETUP) begin
            idx_q <= '0;
        end else if (advance && !at_end) begin
            idx_q <= idx_q + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_line_rasterizer.sv
// Self-checking bench for line_rasterizer against a queue-based line model.
// Pattern scenario is compiled in when LINE_PATTERN_EN is defined.
module tb_line_rasterizer;

    localparam int CW   = 10;
    localparam int AW   = 18;
    localparam int LS   = 640;
    localparam int DH   = 400;
    localparam int COLW = 4;
`ifdef LINE_PATTERN_EN
    localparam bit PAT_ON = 1'b1;
`else
    localparam bit PAT_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic            pr = 1'b1;
    logic [CW-1:0]   x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [COLW-1:0] col = '0;
    logic [15:0]     pat = 16'hFFFF;
    logic            rdy, pv;
    logic [AW-1:0]   addr;
    logic [COLW-1:0] cout;

    always #5 clk = ~clk;

    line_rasterizer #(
        .COORD_WIDTH(CW), .ADDRESS_WIDTH(AW), .LINE_STRIDE(LS),
        .DISPLAY_HEIGHT(DH), .COLOR_WIDTH(COLW)
    ) dut (
        .clock_in(clk), .reset_n_in(rst_n), .enable_in(en),
        .x0_in(x0), .y0_in(y0), .x1_in(x1), .y1_in(y1),
        .color_in(col),
`ifdef LINE_PATTERN_EN
        .pattern_in(pat),
`endif
        .ready_out(rdy), .pixel_valid_out(pv),
        .pixel_ready_in(pr), .address_out(addr), .color_out(cout)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int obs_addr[$], obs_col[$], obs_cyc[$];
    int first_c, done_c, stall_cyc, viol, tmo;

    // Reference: walk the line with plain integers, list drawable addresses
    function automatic int model(int ax0, int ay0, int ax1, int ay1,
                                 logic [15:0] p);
        int dx, dy, sx, sy, err, e2, x, y, i;
        logic [15:0] pe;
        pe = PAT_ON ? p : 16'hFFFF;
        exp_q.delete();
        dx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        dy = (ay1 > ay0) ? ay0 - ay1 : ay1 - ay0;
        sx = (ax0 < ax1) ? 1 : -1;
        sy = (ay0 < ay1) ? 1 : -1;
        err = dx + dy;
        x = ax0;
        y = ay0;
        i = 0;
        forever begin
            if (x < LS && y < DH && pe[i % 16])
                exp_q.push_back((y * LS + x) % (1 << AW));
            if (x == ax1 && y == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
            i++;
        end
        return i + 1;
    endfunction

    task automatic drive_line(input int ax0, input int ay0, input int ax1,
                              input int ay1, input int acol,
                              input logic [15:0] apat, input int stall_beat,
                              input int stall_len, input bit rnd,
                              input int poke_c);
        int c, w, stalls, a_p, col_p;
        bit pv_p, pr_p;
        obs_addr.delete(); obs_col.delete(); obs_cyc.delete();
        first_c = -1; done_c = -1; stall_cyc = 0; viol = 0; tmo = 0;
        stalls = 0; pv_p = 0; pr_p = 1; a_p = 0; col_p = 0;
        @(negedge clk);
        w = 0;
        while (!rdy && w < 100) begin @(negedge clk); w++; end
        if (!rdy) begin tmo = 1; return; end
        x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
        col = COLW'(acol); pat = apat; pr = 1'b1; en = 1'b1;
        c = 0;
        while (c < 6000) begin
            @(negedge clk);
            c++;
            en = 1'b0;
            if (poke_c > 0 && c == poke_c) begin
                x0 = '0; y0 = '0; x1 = '0; y1 = '0; col = 4'h5; en = 1'b1;
            end
            if (rdy) begin done_c = c; break; end
            if (pv_p && !pr_p)
                if (!pv || int'(addr) != a_p || int'(cout) != col_p) viol++;
            if (rnd) pr = ($urandom_range(0, 3) != 0);
            else if (pv && obs_addr.size() == stall_beat && stalls < stall_len) begin
                pr = 1'b0; stalls++;
            end else pr = 1'b1;
            if (pv && first_c < 0) first_c = c;
            if (pv && !pr) stall_cyc++;
            if (pv && pr) begin
                obs_addr.push_back(int'(addr));
                obs_col.push_back(int'(cout));
                obs_cyc.push_back(c);
            end
            pv_p = pv; pr_p = pr; a_p = int'(addr); col_p = int'(cout);
        end
        en = 1'b0;
        pr = 1'b1;
        if (done_c < 0) tmo = 1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", rdy); end
        checks++; if (pv !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", pv); end
        checks++; if (addr !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", addr); end
        checks++; if (cout !== '0) begin errors++; $display("FAIL reset_color got %0d want 0", cout); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (rdy !== 1'b1 || pv !== 1'b0) begin errors++; $display("FAIL post_reset got rdy=%b pv=%b want 1/0", rdy, pv); end
    endtask

    task automatic test_diagonal();
        int n;
        n = model(10, 10, 0, 0, 16'hFFFF);
        drive_line(10, 10, 0, 0, 3, 16'hFFFF, -1, 0, 0, 0);
        checks++; if (tmo != 0) begin errors++; $display("FAIL diag_timeout got %0d want 0", tmo); end
        checks++; if (obs_addr.size() != 11) begin errors++; $display("FAIL diag_count got %0d want 11", obs_addr.size()); end
        if (obs_addr.size() >= 2) begin
            checks++; if (obs_addr[0] != 6410 || obs_addr[1] != 5769) begin errors++; $display("FAIL diag_first got %0d,%0d want 6410,5769", obs_addr[0], obs_addr[1]); end
        end
        for (int k = 0; k < obs_addr.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_addr[k] != exp_q[k] || obs_cyc[k] != 2 + k || obs_col[k] != 3) begin
                errors++;
                $display("FAIL diag_beat%0d got a=%0d c=%0d col=%0d want a=%0d c=%0d col=3", k, obs_addr[k], obs_cyc[k], obs_col[k], exp_q[k], 2 + k);
            end
        end
        checks++; if (first_c != 2) begin errors++; $display("FAIL diag_latency got %0d want 2", first_c); end
        checks++; if (done_c != 2 + n) begin errors++; $display("FAIL diag_ready got %0d want %0d", done_c, 2 + n); end
    endtask

    task automatic test_horizontal();
        int want[4] = '{3200, 3201, 3202, 3203};
        drive_line(0, 5, 3, 5, 10, 16'hFFFF, -1, 0, 0, 0);
        checks++; if (obs_addr.size() != 4) begin errors++; $display("FAIL horiz_count got %0d want 4", obs_addr.size()); end
        for (int k = 0; k < obs_addr.size() && k < 4; k++) begin
            checks++;
            if (obs_addr[k] != want[k] || obs_col[k] != 10) begin
                errors++;
                $display("FAIL horiz_beat%0d got a=%0d col=%0d want a=%0d col=10", k, obs_addr[k], obs_col[k], want[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int want[4] = '{3200, 3201, 3202, 3203};
        drive_line(0, 5, 3, 5, 10, 16'hFFFF, 1, 5, 0, 0);
        checks++; if (obs_addr.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", obs_addr.size()); end
        for (int k = 0; k < obs_addr.size() && k < 4; k++) begin
            checks++; if (obs_addr[k] != want[k]) begin errors++; $display("FAIL bp_beat%0d got %0d want %0d", k, obs_addr[k], want[k]); end
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL bp_stable got %0d violations want 0", viol); end
        checks++; if (stall_cyc != 5) begin errors++; $display("FAIL bp_stalls got %0d want 5", stall_cyc); end
        checks++; if (done_c != 11) begin errors++; $display("FAIL bp_ready got %0d want 11", done_c); end
    endtask

    task automatic test_clip_single();
        drive_line(638, 0, 642, 0, 1, 16'hFFFF, -1, 0, 0, 0);
        checks++; if (obs_addr.size() != 2) begin errors++; $display("FAIL clip_count got %0d want 2", obs_addr.size()); end
        if (obs_addr.size() == 2) begin
            checks++; if (obs_addr[0] != 638 || obs_addr[1] != 639) begin errors++; $display("FAIL clip_addr got %0d,%0d want 638,639", obs_addr[0], obs_addr[1]); end
        end
        checks++; if (done_c - first_c != 5) begin errors++; $display("FAIL clip_ready got %0d want 5", done_c - first_c); end
        drive_line(7, 7, 7, 7, 2, 16'hFFFF, -1, 0, 0, 0);
        checks++; if (obs_addr.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", obs_addr.size()); end
        if (obs_addr.size() == 1) begin
            checks++; if (obs_addr[0] != 4487) begin errors++; $display("FAIL single_addr got %0d want 4487", obs_addr[0]); end
        end
        checks++; if (done_c != 3) begin errors++; $display("FAIL single_ready got %0d want 3", done_c); end
    endtask

    task automatic test_reset_mid();
        int beats, c, bad;
        beats = 0; c = 0; bad = 0;
        @(negedge clk);
        x0 = 10; y0 = 10; x1 = 0; y1 = 0; col = 2; pr = 1'b1; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        while (beats < 3 && c < 50) begin
            if (pv) beats++;
            @(negedge clk);
            c++;
        end
        checks++; if (beats != 3) begin errors++; $display("FAIL rmid_beats got %0d want 3", beats); end
        rst_n = 1'b0;
        #1;
        checks++; if (pv !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL rmid_async got pv=%b rdy=%b want 0/1", pv, rdy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (pv !== 1'b0 || rdy !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rmid_quiet got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_busy_ignore();
        int want[4] = '{3200, 3201, 3202, 3203};
        drive_line(0, 5, 3, 5, 10, 16'hFFFF, -1, 0, 0, 3);
        checks++; if (obs_addr.size() != 4) begin errors++; $display("FAIL busy_count got %0d want 4", obs_addr.size()); end
        for (int k = 0; k < obs_addr.size() && k < 4; k++) begin
            checks++;
            if (obs_addr[k] != want[k] || obs_col[k] != 10) begin
                errors++;
                $display("FAIL busy_beat%0d got a=%0d col=%0d want a=%0d col=10", k, obs_addr[k], obs_col[k], want[k]);
            end
        end
        checks++; if (done_c != 6) begin errors++; $display("FAIL busy_ready got %0d want 6", done_c); end
    endtask

`ifdef LINE_PATTERN_EN
    task automatic test_pattern();
        int want[4] = '{0, 2, 4, 6};
        drive_line(0, 0, 7, 0, 1, 16'h5555, -1, 0, 0, 0);
        checks++; if (obs_addr.size() != 4) begin errors++; $display("FAIL pat_count got %0d want 4", obs_addr.size()); end
        for (int k = 0; k < obs_addr.size() && k < 4; k++) begin
            checks++; if (obs_addr[k] != want[k]) begin errors++; $display("FAIL pat_beat%0d got %0d want %0d", k, obs_addr[k], want[k]); end
        end
        checks++; if (done_c != 10) begin errors++; $display("FAIL pat_ready got %0d want 10", done_c); end
    endtask
`endif

    task automatic test_random();
        int ax0, ay0, ax1, ay1, acol, n;
        logic [15:0] p;
        for (int t = 0; t < 16; t++) begin
            if (t % 4 == 3) begin
                ax0 = $urandom_range(0, 1023); ax1 = $urandom_range(0, 1023);
                ay0 = $urandom_range(0, 1023); ay1 = $urandom_range(0, 1023);
            end else begin
                ax0 = $urandom_range(560, 720); ax1 = $urandom_range(560, 720);
                ay0 = $urandom_range(340, 460); ay1 = $urandom_range(340, 460);
            end
            acol = $urandom_range(0, 15);
            p = 16'($urandom);
            n = model(ax0, ay0, ax1, ay1, p);
            drive_line(ax0, ay0, ax1, ay1, acol, p, -1, 0, 1, 0);
            checks++; if (tmo != 0) begin errors++; $display("FAIL rnd%0d_timeout got %0d want 0", t, tmo); end
            checks++; if (obs_addr.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", t, obs_addr.size(), exp_q.size()); end
            for (int k = 0; k < obs_addr.size() && k < exp_q.size(); k++) begin
                checks++;
                if (obs_addr[k] != exp_q[k] || obs_col[k] != acol) begin
                    errors++;
                    $display("FAIL rnd%0d_beat%0d got a=%0d col=%0d want a=%0d col=%0d", t, k, obs_addr[k], obs_col[k], exp_q[k], acol);
                end
            end
            checks++; if (viol != 0) begin errors++; $display("FAIL rnd%0d_stable got %0d want 0", t, viol); end
            checks++; if (done_c != 2 + n + stall_cyc) begin errors++; $display("FAIL rnd%0d_ready got %0d want %0d", t, done_c, 2 + n + stall_cyc); end
        end
    endtask

    initial begin
        test_reset();
        test_diagonal();
        test_horizontal();
        test_backpressure();
        test_clip_single();
        test_reset_mid();
        test_busy_ignore();
`ifdef LINE_PATTERN_EN
        test_pattern();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
